// File: rtl/kore_opseq.sv
// kore_opseq: multi-cycle instruction sequencer. It accepts one instruction word, reads its source
// registers, runs the execute handshake with a time-out, and produces the next PC.
module kore_opseq #(
  parameter int IR_W    = 32,
  parameter int OPC_W   = 6,
  parameter int RA_W    = 5,
  parameter int PC_W    = 16,
  parameter int EXEC_TO = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ir_valid,
  output logic             ir_ready,
  input  logic [IR_W-1:0]  ir_code,
  input  logic [PC_W-1:0]  pc_in,
  output logic [OPC_W-1:0] opcode,
  output logic             rf_rd,
  output logic [RA_W-1:0]  rf_addr,
  output logic             exec_start,
  input  logic             exec_done,
  input  logic             bc_taken,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_next,
  output logic             opflag,
  output logic             busy,
  output logic             err,
  input  logic             err_clr
);

  localparam int IMM_W = IR_W - OPC_W - 2*RA_W;
  localparam int CNT_W = (EXEC_TO > 1) ? $clog2(EXEC_TO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_TO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RS0  = 3'd1,
    RS1  = 3'd2,
    EXEC = 3'd3,
    DONE = 3'd4
  } state_t;

  // A size cast of a signed operand sign-extends (or truncates) the immediate to PC width.
  function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return PC_W'($signed(imm));
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic [RA_W-1:0]   rs1_r;
  logic [IMM_W-1:0]  imm_r;
  logic [PC_W-1:0]   pc_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [OPC_W-1:0]  ir_opc_s;
  logic [RA_W-1:0]   ir_rs0_s;
  logic [RA_W-1:0]   ir_rs1_s;
  logic [IMM_W-1:0]  ir_imm_s;
  logic              accept_s;
  logic              branch_s;
  logic              two_src_s;
  logic              timeout_s;
  logic              taken_s;
  logic [RA_W-1:0]   rf_addr_s;
  logic [PC_W-1:0]   pc_next_s;

  assign ir_opc_s  = ir_code[IR_W-1 -: OPC_W];
  assign ir_rs0_s  = ir_code[IR_W-OPC_W-1 -: RA_W];
  assign ir_rs1_s  = ir_code[IR_W-OPC_W-RA_W-1 -: RA_W];
  assign ir_imm_s  = ir_code[IMM_W-1:0];
  assign accept_s  = ir_valid & ir_ready;
  assign branch_s  = opcode[OPC_W-1];
  assign two_src_s = opcode[OPC_W-2];

  // Next-state decode, including the time-out and the branch outcome captured on leaving EXEC.
  always_comb begin
    next_state_s = state_r;
    timeout_s    = 1'b0;
    taken_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (ir_opc_s == '0) begin
            next_state_s = DONE;
          end else begin
            next_state_s = RS0;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RS0: begin
        if (two_src_s) begin
          next_state_s = RS1;
        end else begin
          next_state_s = EXEC;
        end
      end
      RS1:  next_state_s = EXEC;
      EXEC: begin
        // exec_done in the last allowed cycle takes priority over the time-out.
        if (exec_done) begin
          next_state_s = DONE;
          taken_s      = bc_taken;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = DONE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = EXEC;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Values the registered outputs take in the state being entered.
  always_comb begin
    rf_addr_s = '0;
    pc_next_s = pc_r + PC_STEP;
    case (next_state_s)
      RS0:     rf_addr_s = ir_rs0_s;
      RS1:     rf_addr_s = rs1_r;
      default: rf_addr_s = '0;
    endcase
    if (state_r == IDLE) begin
      pc_next_s = pc_in + PC_STEP;
    end else if (branch_s && taken_s) begin
      pc_next_s = pc_r + sext_imm(imm_r);
    end else begin
      pc_next_s = pc_r + PC_STEP;
    end
  end

  // State register, instruction latch and EXEC cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      opcode  <= '0;
      rs1_r   <= '0;
      imm_r   <= '0;
      pc_r    <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      if (state_r == IDLE && accept_s) begin
        opcode <= ir_opc_s;
        rs1_r  <= ir_rs1_s;
        imm_r  <= ir_imm_s;
        pc_r   <= pc_in;
      end else begin
        opcode <= opcode;
      end
      if (state_r == EXEC) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Outputs are registered from the next state so each one is aligned with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_ready   <= 1'b0;
      busy       <= 1'b0;
      rf_rd      <= 1'b0;
      rf_addr    <= '0;
      exec_start <= 1'b0;
      pc_load    <= 1'b0;
      opflag     <= 1'b0;
      pc_next    <= '0;
      err        <= 1'b0;
    end else begin
      ir_ready   <= (next_state_s == IDLE);
      busy       <= (next_state_s != IDLE);
      rf_rd      <= (next_state_s == RS0) || (next_state_s == RS1);
      rf_addr    <= rf_addr_s;
      exec_start <= (next_state_s == EXEC) && (state_r != EXEC);
      pc_load    <= (next_state_s == DONE);
      opflag     <= (next_state_s == DONE);
      if (next_state_s == DONE) begin
        pc_next <= pc_next_s;
      end else begin
        pc_next <= pc_next;
      end
      if (timeout_s) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end else begin
        err <= err;
      end
    end
  end

endmodule

// File: tb/tb_kore_opseq.sv
// Bench for kore_opseq: directed cases plus random instructions, checked against a
// field-level reference model through scoreboard queues drained by an output monitor.
module tb_kore_opseq;

  localparam int IR_W    = 32;
  localparam int OPC_W   = 6;
  localparam int RA_W    = 5;
  localparam int PC_W    = 16;
  localparam int EXEC_TO = 15;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             ir_valid  = 1'b0;
  logic [IR_W-1:0]  ir_code   = '0;
  logic [PC_W-1:0]  pc_in     = '0;
  logic             exec_done = 1'b0;
  logic             bc_taken  = 1'b0;
  logic             err_clr   = 1'b0;
  logic             ir_ready;
  logic [OPC_W-1:0] opcode;
  logic             rf_rd;
  logic [RA_W-1:0]  rf_addr;
  logic             exec_start;
  logic             pc_load;
  logic [PC_W-1:0]  pc_next;
  logic             opflag;
  logic             busy;
  logic             err;

  kore_opseq #(.IR_W(IR_W), .OPC_W(OPC_W), .RA_W(RA_W), .PC_W(PC_W), .EXEC_TO(EXEC_TO)) dut (
    .clk(clk), .rst(rst), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_code(ir_code),
    .pc_in(pc_in), .opcode(opcode), .rf_rd(rf_rd), .rf_addr(rf_addr), .exec_start(exec_start),
    .exec_done(exec_done), .bc_taken(bc_taken), .pc_load(pc_load), .pc_next(pc_next),
    .opflag(opflag), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [PC_W-1:0] pcn; logic err; logic [OPC_W-1:0] opc; int cyc; } done_t;
  typedef struct { logic [RA_W-1:0] addr; int cyc; } rd_t;
  typedef struct { int delay; logic bc; } ex_t;

  done_t done_q[$];
  rd_t   rd_q[$];
  int    es_q[$];
  ex_t   ex_q[$];

  int               vectors     = 0;
  int               miscompares = 0;
  logic             model_err   = 1'b0;
  logic [OPC_W-1:0] cur_opc     = '0;
  int               ready_chk   = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one instruction, record the reference outcome once it is accepted.
  task automatic issue(input logic [31:0] ir, input logic [15:0] pc, input int delay,
                       input logic bc, output int done_cyc, output bit ok);
    int bound, acc, opc, rs0, rs1, imm, simm, entry, pcn;
    bit br, two, tmo, taken;
    @(negedge clk);
    ir_valid = 1'b1;
    ir_code  = ir;
    pc_in    = pc;
    bound    = 0;
    while (ir_ready !== 1'b1 && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    if (ir_ready !== 1'b1) begin
      check("accept_wait", {31'd0, ir_ready}, 32'd1);
      ir_valid = 1'b0;
      done_cyc = cyc;
      ok       = 1'b0;
      return;
    end
    ok    = 1'b1;
    acc   = cyc;
    opc   = int'(ir >> 26);
    rs0   = int'((ir >> 21) & 32'd31);
    rs1   = int'((ir >> 16) & 32'd31);
    imm   = int'(ir & 32'hFFFF);
    simm  = (imm >= 32768) ? imm - 65536 : imm;
    br    = (opc >= 32);
    two   = (((opc >> 4) & 1) == 1);
    tmo   = (opc != 0) && (delay >= EXEC_TO);
    taken = br && !tmo && (bc == 1'b1);
    pcn   = taken ? ((int'(pc) + simm) & 65535) : ((int'(pc) + 1) & 65535);
    if (opc == 0) begin
      done_cyc = acc + 1;
    end else begin
      rd_q.push_back('{RA_W'(rs0), acc + 1});
      if (two) rd_q.push_back('{RA_W'(rs1), acc + 2});
      entry = acc + 2 + int'(two);
      es_q.push_back(entry);
      ex_q.push_back('{delay, bc});
      done_cyc = entry + (tmo ? EXEC_TO : delay + 1);
    end
    model_err = model_err | tmo;
    done_q.push_back('{PC_W'(pcn), model_err, OPC_W'(opc), done_cyc});
    @(posedge clk);
    #1;
    cur_opc = OPC_W'(opc);
  endtask

  // Let the instruction run; in hold mode ir_valid stays high with junk words while busy.
  task automatic wait_done(input int done_cyc, input bit hold);
    while (cyc < done_cyc) begin
      @(negedge clk);
      if (hold) begin
        ir_code = $urandom;
        pc_in   = 16'($urandom);
      end else begin
        ir_valid = 1'b0;
      end
    end
    if (!hold) ir_valid = 1'b0;
  endtask

  task automatic run(input logic [31:0] ir, input logic [15:0] pc, input int delay,
                     input logic bc, input bit hold);
    int  dc;
    bit  ok;
    issue(ir, pc, delay, bc, dc, ok);
    if (ok) wait_done(dc, hold);
  endtask

  task automatic clear_err();
    @(negedge clk);
    ir_valid = 1'b0;
    err_clr  = 1'b1;
    @(negedge clk);
    err_clr   = 1'b0;
    model_err = 1'b0;
    check("err_clr", {31'd0, err}, 32'd0);
  endtask

  task automatic do_reset(input int hold_cycles);
    rst      = 1'b1;
    ir_valid = 1'b0;
    err_clr  = 1'b0;
    #1;
    check("rst_opcode", {26'd0, opcode}, 32'd0);
    check("rst_rf_rd", {31'd0, rf_rd}, 32'd0);
    check("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    check("rst_exec_start", {31'd0, exec_start}, 32'd0);
    check("rst_pc_load", {31'd0, pc_load}, 32'd0);
    check("rst_pc_next", {16'd0, pc_next}, 32'd0);
    check("rst_opflag", {31'd0, opflag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ir_ready", {31'd0, ir_ready}, 32'd0);
    done_q.delete();
    rd_q.delete();
    es_q.delete();
    ex_q.delete();
    model_err = 1'b0;
    cur_opc   = '0;
    ready_chk = -1;
    repeat (hold_cycles) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_clock", {31'd0, ir_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_release", {31'd0, ir_ready}, 32'd1);
  endtask

  // Execute-unit model: answers each exec_start after the delay queued for that instruction.
  initial begin
    ex_t cur;
    int  k;
    bit  active;
    active = 1'b0;
    k      = 0;
    cur    = '{0, 1'b0};
    forever begin
      @(negedge clk);
      if (rst) begin
        active    = 1'b0;
        exec_done = 1'b0;
        continue;
      end
      if (exec_start === 1'b1 && ex_q.size() > 0) begin
        cur    = ex_q.pop_front();
        active = 1'b1;
        k      = 0;
      end else if (active) begin
        k++;
      end
      if (active) begin
        if (k == cur.delay) begin
          exec_done = 1'b1;
          bc_taken  = cur.bc;
          active    = 1'b0;
        end else begin
          exec_done = 1'b0;
          bc_taken  = 1'($urandom);
          if (k >= EXEC_TO - 1) active = 1'b0;
        end
      end else begin
        exec_done = 1'($urandom);
        bc_taken  = 1'($urandom);
      end
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT presents a read, start or completion.
  initial begin
    rd_t   r;
    done_t d;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (ready_chk == cyc) begin
        check("ready_after_done", {31'd0, ir_ready}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
      end
      if (rf_rd !== 1'b1) begin
        check("rf_addr_idle", {27'd0, rf_addr}, 32'd0);
      end else if (rd_q.size() == 0) begin
        check("unexpected_rf_rd", {31'd0, rf_rd}, 32'd0);
      end else begin
        r = rd_q.pop_front();
        check("rf_addr", {27'd0, rf_addr}, {27'd0, r.addr});
        check("rf_rd_cycle", cyc, r.cyc);
      end
      if (exec_start === 1'b1) begin
        if (es_q.size() == 0) check("unexpected_exec_start", {31'd0, exec_start}, 32'd0);
        else check("exec_start_cycle", cyc, es_q.pop_front());
      end
      check("opcode_hold", {26'd0, opcode}, {26'd0, cur_opc});
      if (pc_load === 1'b1 || opflag === 1'b1) begin
        check("opflag_vs_pc_load", {31'd0, opflag}, {31'd0, pc_load});
        if (done_q.size() == 0) begin
          check("unexpected_done", {31'd0, pc_load | opflag}, 32'd0);
        end else begin
          d = done_q.pop_front();
          check("pc_next", {16'd0, pc_next}, {16'd0, d.pcn});
          check("err_at_done", {31'd0, err}, {31'd0, d.err});
          check("opcode_at_done", {26'd0, opcode}, {26'd0, d.opc});
          check("done_cycle", cyc, d.cyc);
          check("busy_at_done", {31'd0, busy}, 32'd1);
        end
        ready_chk = cyc + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  dc;
    bit  ok;
    int  sel;
    int  delay;
    logic [31:0] ir;
    #2;
    do_reset(3);

    run(32'h0000_0000, 16'h0010, 0, 1'b0, 1'b0);
    run(32'h4467_0000, 16'h0100, 2, 1'b0, 1'b0);
    run(32'h8020_FFFC, 16'h0002, 0, 1'b1, 1'b0);
    run(32'h8020_FFFC, 16'h0002, 0, 1'b0, 1'b0);
    run(32'hC461_0007, 16'hFFFC, 3, 1'b1, 1'b0);

    run(32'h0400_0000, 16'h1234, 40, 1'b1, 1'b0);
    run(32'h8420_0010, 16'h0200, 1, 1'b1, 1'b0);
    clear_err();
    run(32'h8420_0010, 16'h0300, EXEC_TO - 1, 1'b1, 1'b0);

    @(negedge clk);
    err_clr = 1'b1;
    run(32'h0400_0000, 16'h0040, 40, 1'b0, 1'b0);
    @(negedge clk);
    check("err_clr_after_timeout", {31'd0, err}, 32'd0);
    err_clr   = 1'b0;
    model_err = 1'b0;

    issue(32'h0400_0000, 16'h0500, 40, 1'b0, dc, ok);
    ir_valid = 1'b0;
    if (ok) begin
      while (cyc < dc - EXEC_TO + 2) @(negedge clk);
      do_reset(2);
    end
    run(32'h0460_0000, 16'h0600, 1, 1'b0, 1'b0);

    run(32'h4467_0000, 16'h0700, 0, 1'b0, 1'b1);
    run(32'h0000_0000, 16'h0710, 0, 1'b0, 1'b1);
    run(32'h8020_0005, 16'h0720, 2, 1'b1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      ir  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) ir[31:26] = 6'd0;
      sel = $urandom_range(0, 9);
      if (sel < 6)       delay = $urandom_range(0, 4);
      else if (sel < 8)  delay = $urandom_range(5, 13);
      else if (sel == 8) delay = $urandom_range(EXEC_TO - 1, EXEC_TO);
      else               delay = 40;
      run(ir, 16'($urandom), delay, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) clear_err();
    end

    @(negedge clk);
    ir_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("done_q_drained", done_q.size(), 32'd0);
    check("rd_q_drained", rd_q.size(), 32'd0);
    check("es_q_drained", es_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
